// File: rtl/bytes_to_dibits_pkg.sv
// Shared constants, shifter state type and sizing helpers for the byte-to-dibit serialiser.
package bytes_to_dibits_pkg;

    localparam int unsigned BYTE_LEN_DEFAULT   = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned DIBIT_W            = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bytes_to_dibits_if.sv
// Byte-in / dibit-out stream bundle between a byte source and the serialiser.
interface bytes_to_dibits_if
    import bytes_to_dibits_pkg::*;
#(
    parameter int unsigned BYTE_LEN = BYTE_LEN_DEFAULT
);

    logic                inclk;
    logic [BYTE_LEN-1:0] in;
    logic                done_in;
    logic [DIBIT_W-1:0]  out;
    logic                outclk;
    logic                idle;
    logic                done_out;
    logic                overflow;

    modport master (
        output inclk,
        output in,
        output done_in,
        input  out,
        input  outclk,
        input  idle,
        input  done_out,
        input  overflow
    );

    modport slave (
        input  inclk,
        input  in,
        input  done_in,
        output out,
        output outclk,
        output idle,
        output done_out,
        output overflow
    );

endinterface

// File: rtl/bytes_to_dibits_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a pop in the same cycle frees a slot for a push.
module bytes_to_dibits_byte_fifo
    import bytes_to_dibits_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_LEN_DEFAULT,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_ok  = push && (!full_c || pop);
        pop_ok   = pop && !empty_c;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bytes_to_dibits.sv
// Serialises bytes into dibits, LSB-first, with a bypass path, input FIFO and end-of-stream marker.
module bytes_to_dibits
    import bytes_to_dibits_pkg::*;
#(
    parameter int unsigned BYTE_LEN   = BYTE_LEN_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    bytes_to_dibits_if.slave bus
);

    localparam int unsigned DIBITS = BYTE_LEN / DIBIT_W;
    localparam int unsigned CW     = cnt_width(DIBITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIBITS - 1);

    shift_state_e        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BYTE_LEN-1:0] sreg_q, sreg_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [DIBIT_W-1:0]  out_q, out_d;
    logic                outclk_q, outclk_d;
    logic                idle_q, idle_d;
    logic                done_out_q, done_out_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [BYTE_LEN-1:0] fifo_rdata_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic                last_c;
    logic                bypass_c;
    logic                done_req_c;

    bytes_to_dibits_byte_fifo #(
        .WIDTH (BYTE_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .wdata   (bus.in),
        .pop     (fifo_pop),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Next shifter state plus the registered outputs describing the dibit shown next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        out_d      = '0;
        outclk_d   = 1'b0;
        idle_d     = 1'b0;
        done_out_d = 1'b0;
        fifo_pop   = 1'b0;
        fifo_push  = 1'b0;
        bypass_c   = 1'b0;
        last_c     = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
        done_req_c = done_q || bus.done_in;

        if ((state_q == ST_SHIFT) && !last_c) begin
            cnt_d  = cnt_q + CW'(1);
            sreg_d = sreg_q >> DIBIT_W;
        end else if (!fifo_empty_c) begin
            fifo_pop = 1'b1;
            state_d  = ST_SHIFT;
            cnt_d    = '0;
            sreg_d   = fifo_rdata_c;
        end else if (bus.inclk) begin
            // Empty FIFO and free shifter: take the byte straight from the port.
            bypass_c = 1'b1;
            state_d  = ST_SHIFT;
            cnt_d    = '0;
            sreg_d   = bus.in;
        end else begin
            state_d  = ST_IDLE;
        end

        fifo_push = bus.inclk && !bypass_c;
        if (fifo_push && fifo_full_c && !fifo_pop) begin
            ovf_d = 1'b1;
        end

        outclk_d = (state_d == ST_SHIFT);
        out_d    = outclk_d ? sreg_d[DIBIT_W-1:0] : '0;

        // Going IDLE implies the FIFO drains empty too, since any waiting byte would load.
        idle_d     = (state_d == ST_IDLE);
        done_out_d = done_req_c && idle_d;
        done_d     = done_req_c && !idle_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            out_q      <= '0;
            outclk_q   <= 1'b0;
            idle_q     <= 1'b1;
            done_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            out_q      <= out_d;
            outclk_q   <= outclk_d;
            idle_q     <= idle_d;
            done_out_q <= done_out_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.outclk   = outclk_q;
    assign bus.idle     = idle_q;
    assign bus.done_out = done_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bytes_to_dibits.sv
// Directed and random checks of bytes_to_dibits against a queue-based dibit stream model.
module tb_bytes_to_dibits;

    localparam int unsigned BL    = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rstn;

    bytes_to_dibits_if #(.BYTE_LEN(BL)) bif ();

    bytes_to_dibits #(
        .BYTE_LEN   (BL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model: bytes waiting, plus the not-yet-retired dibits of the byte on the wire.
    logic [BL-1:0] m_fifo [$];
    logic [1:0]    m_dib  [$];
    bit            m_pend;
    bit            m_ovf;
    bit            e_outclk, e_idle, e_done;
    logic [1:0]    e_out;

    int         n_checks;
    int         n_fail;
    int         cyc;
    logic [1:0] obs [$];
    int         n_oc, first_oc, last_oc, n_done, done_cyc;
    logic [BL-1:0] rom [62];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic load_byte(input logic [BL-1:0] b);
        for (int i = 0; i < int'(BL / 2); i++) m_dib.push_back(b[2*i +: 2]);
    endtask

    task automatic model_edge(input bit ic, input logic [BL-1:0] d, input bit dn, input bit r);
        bit taken;
        if (!r) begin
            m_fifo.delete();
            m_dib.delete();
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            taken = 0;
            if (m_dib.size() > 0) void'(m_dib.pop_front());
            if (m_dib.size() == 0) begin
                if (m_fifo.size() > 0) load_byte(m_fifo.pop_front());
                else if (ic) begin
                    load_byte(d);
                    taken = 1;
                end
            end
            if (ic && !taken) begin
                if (m_fifo.size() < int'(DEPTH)) m_fifo.push_back(d);
                else m_ovf = 1;
            end
            m_pend = m_pend | dn;
        end
        e_outclk = (m_dib.size() > 0);
        e_out    = e_outclk ? m_dib[0] : 2'b00;
        e_idle   = (m_dib.size() == 0) && (m_fifo.size() == 0);
        e_done   = r && m_pend && e_idle;
        if (e_done) m_pend = 0;
    endtask

    task automatic step(input bit ic, input logic [BL-1:0] d, input bit dn, input bit r);
        bif.inclk   = ic;
        bif.in      = d;
        bif.done_in = dn;
        rstn        = r;
        @(posedge clk);
        model_edge(ic, d, dn, r);
        #1;
        cyc++;
        check("outclk",   32'(bif.outclk),   32'(e_outclk));
        check("out",      32'(bif.out),      32'(e_out));
        check("idle",     32'(bif.idle),     32'(e_idle));
        check("done_out", 32'(bif.done_out), 32'(e_done));
        check("overflow", 32'(bif.overflow), 32'(m_ovf));
        if (bif.outclk === 1'b1) begin
            obs.push_back(bif.out);
            n_oc++;
            if (first_oc < 0) first_oc = cyc;
            last_oc = cyc;
        end
        if (bif.done_out === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic clear_obs();
        obs.delete();
        n_oc     = 0;
        first_oc = -1;
        last_oc  = -1;
        n_done   = 0;
        done_cyc = -1;
    endtask

    // Reflected CRC-32 fed two bits at a time, bit 0 of each dibit first.
    function automatic logic [31:0] crc_dibits(input logic [1:0] q [$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 2; b++) begin
                if (c[0] ^ q[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Byte-wise CRC-32 of the ROM stream as the golden reference.
    function automatic logic [31:0] crc_rom();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 62; i++) begin
            c = c ^ {24'h0, rom[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    initial begin
        logic [1:0] exp_b4 [4];
        int start;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_pend   = 0;
        m_ovf    = 0;
        bif.inclk   = 1'b0;
        bif.in      = '0;
        bif.done_in = 1'b0;
        rstn        = 1'b0;
        clear_obs();

        // Reset held with inclk toggling.
        for (int i = 0; i < 5; i++) step(1'(i % 2), 8'($urandom), 1'b0, 1'b0);

        // Single byte 0xB4 then done_in two cycles later.
        exp_b4[0] = 2'b00; exp_b4[1] = 2'b01; exp_b4[2] = 2'b11; exp_b4[3] = 2'b10;
        clear_obs();
        start = cyc;
        step(1'b1, 8'hB4, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle_steps(6);
        check("b4_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("b4_dibit", 32'(obs[i]), 32'(exp_b4[i]));
        check("b4_latency", 32'(first_oc - start), 32'd1);
        check("b4_gapfree", 32'(last_oc - first_oc), 32'd3);
        check("b4_done_cnt", 32'(n_done), 32'd1);
        check("b4_done_pos", 32'(done_cyc - last_oc), 32'd1);
        check("b4_idle", 32'(bif.idle), 32'd1);

        // 62-byte stream, one byte every four cycles.
        for (int i = 0; i < 62; i++) rom[i] = 8'((i * 37 + 5) ^ (i << 3));
        clear_obs();
        for (int i = 0; i < 62; i++) begin
            step(1'b1, rom[i], 1'b0, 1'b1);
            idle_steps(3);
        end
        idle_steps(4);
        check("stream_outclk", 32'(n_oc), 32'd248);
        check("stream_gapfree", 32'(last_oc - first_oc + 1), 32'd248);
        check("stream_crc", crc_dibits(obs), crc_rom());

        // Back-to-back burst: bypass byte, FIFO fills, later bytes dropped.
        clear_obs();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
        idle_steps(30);
        // Byte 0 bypasses, byte 1 pops in time for byte 4, bytes 6 and 7 find the FIFO full.
        check("burst_dibits", 32'(obs.size()), 32'd24);
        check("burst_overflow", 32'(bif.overflow), 32'd1);

        // Last byte's inclk coincides with done_in.
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'($urandom), 1'(i == 2), 1'b1);
            if (i < 2) idle_steps(3);
        end
        idle_steps(8);
        check("eos_outclk", 32'(n_oc), 32'd12);
        check("eos_done_cnt", 32'(n_done), 32'd1);
        check("eos_done_pos", 32'(done_cyc - last_oc), 32'd1);

        // Reset during the second dibit with a done pending.
        clear_obs();
        step(1'b1, 8'hE7, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("abort_outclk", 32'(bif.outclk), 32'd0);
        idle_steps(5);
        check("abort_dibits", 32'(n_oc), 32'd2);
        check("abort_done", 32'(n_done), 32'd0);
        check("abort_idle", 32'(bif.idle), 32'd1);
        clear_obs();
        step(1'b1, 8'h6C, 1'b0, 1'b1);
        idle_steps(6);
        check("after_abort_cnt", 32'(obs.size()), 32'd4);
        check("after_abort_d0", 32'(obs[0]), 32'd0);
        check("after_abort_d3", 32'(obs[3]), 32'd1);

        // Random traffic, done markers and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 2) == 0), 8'($urandom),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 299) != 0));
        end
        idle_steps(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
